// File: rtl/cswap.sv
// ---------------------------------------------------------------------------
// cswap -- registered Fredkin (controlled-swap) gate
//
// A is the control bit. When A=1 the data operands B and C are exchanged,
// and when A=0 they pass straight through. The swap applies to every bit
// position under the one control bit. Each output comes directly from a
// flop, so no combinational path runs from any input to any output. The
// result appears exactly one cycle after a valid input, and the gate
// accepts a new input every cycle.
//
// Parameters
//   WIDTH       width of B, C, B1 and C1 (1..64)
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset (the integrator synchronises
//               its deassertion)
//   in_valid    qualifies A, B and C this cycle
//   A           control: 1 = swap, 0 = pass through
//   B, C        data operands
//   out_valid   A1/B1/C1 hold a result produced from a valid input
//   A1          registered A
//   B1          registered (A ? C : B)
//   C1          registered (A ? B : C)
//   swap_count  saturating count of accepted inputs with A=1
//               (this port exists only with CSWAP_SWAP_COUNT_EN)
//
// Configuration
//   CSWAP_SWAP_COUNT_EN  when defined, adds the swap_count port and counter
// ---------------------------------------------------------------------------
module cswap #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             A,
    input  logic [WIDTH-1:0] B,
    input  logic [WIDTH-1:0] C,
    output logic             out_valid,
    output logic             A1,
    output logic [WIDTH-1:0] B1,
    output logic [WIDTH-1:0] C1
`ifdef CSWAP_SWAP_COUNT_EN
    ,
    output logic [15:0]      swap_count
`endif
);

    logic             out_valid_q, out_valid_d;
    logic             a1_q, a1_d;
    logic [WIDTH-1:0] b1_q, b1_d;
    logic [WIDTH-1:0] c1_q, c1_d;

    // Next-state logic for the result registers. These registers hold their
    // value while in_valid is low. The valid flag simply follows in_valid,
    // which gives a one-cycle latency.
    always_comb begin
        out_valid_d = in_valid;
        a1_d        = a1_q;
        b1_d        = b1_q;
        c1_d        = c1_q;
        if (in_valid) begin
            a1_d = A;
            b1_d = A ? C : B;
            c1_d = A ? B : C;
        end
    end

    // Result registers. Reset clears them immediately, without waiting for
    // a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            a1_q        <= 1'b0;
            b1_q        <= '0;
            c1_q        <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            a1_q        <= a1_d;
            b1_q        <= b1_d;
            c1_q        <= c1_d;
        end
    end

    assign out_valid = out_valid_q;
    assign A1        = a1_q;
    assign B1        = b1_q;
    assign C1        = c1_q;

`ifdef CSWAP_SWAP_COUNT_EN
    logic [15:0] swap_count_q, swap_count_d;

    // Count each accepted swap. The counter sticks at all-ones rather than
    // wrapping back to zero.
    always_comb begin
        swap_count_d = swap_count_q;
        if (in_valid && A && (swap_count_q != 16'hFFFF)) begin
            swap_count_d = swap_count_q + 16'd1;
        end
    end

    // Counter register, cleared together with the result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            swap_count_q <= 16'd0;
        end else begin
            swap_count_q <= swap_count_d;
        end
    end

    assign swap_count = swap_count_q;
`endif

endmodule

// File: tb/tb_cswap.sv
// ---------------------------------------------------------------------------
// tb_cswap -- self-checking bench for cswap
//
// Three instances are used:
//   d1   WIDTH=1, for the truth table, hold, and asynchronous reset cases
//   d8   WIDTH=8, for wide data and randomized traffic
//   d8b  WIDTH=8, fed from the outputs of d8, so that the cascade
//        reproduces each input two cycles later
// The expected values come from a bit-level Fredkin reference function and
// from a small queue-free scoreboard.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cswap;

    logic clk;
    logic rst_n;

    logic       iv1, ai1, bi1, ci1;
    logic       ov1, ao1, bo1, co1;

    logic       iv8, ai8;
    logic [7:0] bi8, ci8;
    logic       ov8, ao8;
    logic [7:0] bo8, co8;

    logic       ov8b, ao8b;
    logic [7:0] bo8b, co8b;

`ifdef CSWAP_SWAP_COUNT_EN
    logic [15:0] cnt1, cnt8, cnt8b;
`endif

    int check_count;
    int pass_count;
    int swap_model;

    cswap #(.WIDTH(1)) d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv1),
        .A(ai1), .B(bi1), .C(ci1),
        .out_valid(ov1), .A1(ao1), .B1(bo1), .C1(co1)
`ifdef CSWAP_SWAP_COUNT_EN
        , .swap_count(cnt1)
`endif
    );

    cswap #(.WIDTH(8)) d8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8),
        .A(ai8), .B(bi8), .C(ci8),
        .out_valid(ov8), .A1(ao8), .B1(bo8), .C1(co8)
`ifdef CSWAP_SWAP_COUNT_EN
        , .swap_count(cnt8)
`endif
    );

    cswap #(.WIDTH(8)) d8b (
        .clk(clk), .rst_n(rst_n), .in_valid(ov8),
        .A(ao8), .B(bo8), .C(co8),
        .out_valid(ov8b), .A1(ao8b), .B1(bo8b), .C1(co8b)
`ifdef CSWAP_SWAP_COUNT_EN
        , .swap_count(cnt8b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference gate, evaluated one bit position at a time.
    function automatic logic [16:0] fredkin(input logic a, input logic [7:0] b,
                                            input logic [7:0] c);
        logic [7:0] ob, oc;
        for (int i = 0; i < 8; i++) begin
            if (a) begin
                ob[i] = c[i];
                oc[i] = b[i];
            end else begin
                ob[i] = b[i];
                oc[i] = c[i];
            end
        end
        return {a, ob, oc};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic a, input logic [7:0] b,
                                 input logic [7:0] c);
        iv8 = v;
        ai8 = a;
        bi8 = b;
        ci8 = c;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0]  tt_exp [8];
        logic [16:0] cur, prev, model;
        logic        v, a;
        logic [7:0]  b, c;

        check_count = 0;
        pass_count  = 0;
        swap_model  = 0;
        tt_exp = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b110, 3'b101, 3'b111};

        rst_n = 1'b1;
        iv1 = 0; ai1 = 0; bi1 = 0; ci1 = 0;
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);

        // Reset state
        #2 rst_n = 1'b0;
        #2;
        checkOutput("reset_ov8", {31'd0, ov8}, 32'd0);
        checkOutput("reset_d8", {15'd0, ao8, bo8, co8}, 32'd0);
        checkOutput("reset_d1", {28'd0, ov1, ao1, bo1, co1}, 32'd0);

        // Inputs presented during reset are discarded
        applyStimulus(1'b1, 1'b1, 8'hAA, 8'h55);
        iv1 = 1; ai1 = 1; bi1 = 1; ci1 = 0;
        tick();
        tick();
        checkOutput("in_reset_ov8", {31'd0, ov8}, 32'd0);
        #2;
        rst_n = 1'b1;
        iv1 = 0;
        applyStimulus(1'b0, 1'b1, 8'hAA, 8'h55);
        tick();
        checkOutput("post_release_ov8", {31'd0, ov8}, 32'd0);
        checkOutput("post_release_d8", {15'd0, ao8, bo8, co8}, 32'd0);

        // Wide data, swap then pass-through; the cascade restores the first
        applyStimulus(1'b1, 1'b1, 8'hA5, 8'h3C);
        tick();
        checkOutput("wide_swap_ov", {31'd0, ov8}, 32'd1);
        checkOutput("wide_swap", {15'd0, ao8, bo8, co8}, {15'd0, 1'b1, 8'h3C, 8'hA5});
        applyStimulus(1'b1, 1'b0, 8'hA5, 8'h3C);
        tick();
        checkOutput("wide_pass", {15'd0, ao8, bo8, co8}, {15'd0, 1'b0, 8'hA5, 8'h3C});
        checkOutput("wide_cascade", {15'd0, ao8b, bo8b, co8b}, {15'd0, 1'b1, 8'hA5, 8'h3C});
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);

        // Truth table on the single-bit instance
        for (int k = 0; k < 8; k++) begin
            logic [2:0] vin;
            vin = 3'(k);
            iv1 = 1;
            {ai1, bi1, ci1} = vin;
            tick();
            checkOutput($sformatf("tt_%0d_ov", k), {31'd0, ov1}, 32'd1);
            checkOutput($sformatf("tt_%0d", k), {29'd0, ao1, bo1, co1}, {29'd0, tt_exp[k]});
        end

        // Hold: the result of input 101 stays while in_valid is low
        iv1 = 1; {ai1, bi1, ci1} = 3'b101;
        tick();
        checkOutput("hold_load", {29'd0, ao1, bo1, co1}, 32'b110);
        iv1 = 0; {ai1, bi1, ci1} = 3'b011;
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput($sformatf("hold_%0d_ov", k), {31'd0, ov1}, 32'd0);
            checkOutput($sformatf("hold_%0d", k), {29'd0, ao1, bo1, co1}, 32'b110);
        end

        // Asynchronous reset asserted between edges while the output is 111
        iv1 = 1; {ai1, bi1, ci1} = 3'b111;
        tick();
        checkOutput("areset_pre", {28'd0, ov1, ao1, bo1, co1}, 32'b1111);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("areset_d1", {28'd0, ov1, ao1, bo1, co1}, 32'd0);
        checkOutput("areset_d8", {14'd0, ov8, ao8, bo8, co8}, 32'd0);
        #1 rst_n = 1'b1;
        iv1 = 0;
        tick();
        checkOutput("areset_after", {28'd0, ov1, ao1, bo1, co1}, 32'd0);
        swap_model = 0;

        // Cascade with continuous random valid inputs
        prev = '0;
        for (int i = 0; i < 1000; i++) begin
            a = 1'($urandom_range(0, 1));
            b = 8'($urandom_range(0, 255));
            c = 8'($urandom_range(0, 255));
            cur = {a, b, c};
            applyStimulus(1'b1, a, b, c);
            if (a) swap_model++;
            tick();
            checkOutput("casc_stage1", {15'd0, ao8, bo8, co8}, {15'd0, fredkin(a, b, c)});
            checkOutput("casc_ones", $countones({ao8, bo8, co8}), $countones(cur));
            if (i > 0) begin
                checkOutput("casc_stage2", {14'd0, ov8b, ao8b, bo8b, co8b},
                            {14'd0, 1'b1, prev});
            end
            prev = cur;
        end

        // Random in_valid, checking hold behaviour against the scoreboard
        model = fredkin(prev[16], prev[15:8], prev[7:0]);
        for (int i = 0; i < 200; i++) begin
            v = ($urandom_range(0, 3) != 0);
            a = 1'($urandom_range(0, 1));
            b = 8'($urandom_range(0, 255));
            c = 8'($urandom_range(0, 255));
            applyStimulus(v, a, b, c);
            if (v) begin
                model = fredkin(a, b, c);
                if (a) swap_model++;
            end
            tick();
            checkOutput("rand_ov", {31'd0, ov8}, {31'd0, v});
            checkOutput("rand_data", {15'd0, ao8, bo8, co8}, {15'd0, model});
        end
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
        tick();

`ifdef CSWAP_SWAP_COUNT_EN
        checkOutput("cnt_random", {16'd0, cnt8}, 32'(swap_model));

        // Count of 5 swaps among 8 accepted inputs, after a fresh reset
        #2 rst_n = 1'b0;
        #1;
        checkOutput("cnt_reset", {16'd0, cnt8}, 32'd0);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            applyStimulus(1'b1, (k < 5), 8'(k), 8'hF0);
            tick();
        end
        applyStimulus(1'b0, 1'b1, 8'h00, 8'h00);
        tick();
        checkOutput("cnt_five", {16'd0, cnt8}, 32'd5);

        // Drive the counter up to its ceiling and past it
        applyStimulus(1'b1, 1'b1, 8'h12, 8'h34);
        for (int k = 0; k < 65530; k++) @(posedge clk);
        #1;
        checkOutput("cnt_near_top", {16'd0, cnt8}, 32'd65535);
        for (int k = 0; k < 5; k++) tick();
        checkOutput("cnt_saturate", {16'd0, cnt8}, 32'd65535);
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
        tick();
`endif

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/cswap.md
CSWAP -- requirements
Module: cswap

Interface
REQ-001 Parameter WIDTH, default 1, bit width of the swapped data operands B, C, B1, C1; legal range 1..64.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assertion, active-low.
REQ-004 in_valid  input  1  qualifies A, B and C in the current cycle.
REQ-005 A  input  1  control bit: 1 means swap, 0 means pass through.
REQ-006 B  input  WIDTH  first data operand.
REQ-007 C  input  WIDTH  second data operand.
REQ-008 out_valid  output  1  A1, B1 and C1 hold a result produced from a valid input.
REQ-009 A1  output  1  registered copy of A.
REQ-010 B1  output  WIDTH  registered B if A=0, registered C if A=1.
REQ-011 C1  output  WIDTH  registered C if A=0, registered B if A=1.
REQ-012 swap_count  output  16  number of accepted inputs with A=1; present only when CSWAP_SWAP_COUNT_EN is defined.

Function
REQ-013 The module SHALL implement a registered Fredkin (controlled-swap) gate, with every output driven directly from a flop.
REQ-014 On a rising clk edge with in_valid=1, the module SHALL load A1<=A, B1<=(A?C:B) and C1<=(A?B:C).
REQ-015 The module SHALL set out_valid<=in_valid on every rising clk edge, giving a latency of exactly 1 cycle with no back-pressure.
REQ-016 On a rising clk edge with in_valid=0, A1, B1 and C1 SHALL hold their previous values.
REQ-017 The swap SHALL apply independently to every bit position of B and C under the single control bit A.
REQ-018 For every accepted input, the outputs SHALL conserve ones: popcount({A1,B1,C1}) equals popcount({A,B,C}).
REQ-019 Applying the module to its own output, with in_valid held at 1, SHALL return the original {A,B,C} two cycles after the first input (the gate is self-inverse).
REQ-020 Back-to-back valid inputs SHALL be accepted every cycle, with no bubbles and no state beyond the output registers and the counter.
REQ-021 The module SHALL contain no combinational path from any input to any output.

Reset
REQ-022 While rst_n=0, the module SHALL drive out_valid=0, A1=0, B1=0 and C1=0 immediately, without waiting for a clk edge.
REQ-023 While rst_n=0, swap_count SHALL be 0 (when CSWAP_SWAP_COUNT_EN is defined).
REQ-024 Reset released mid-stream SHALL discard any input presented during reset; the first result SHALL appear one cycle after the first edge where rst_n=1 and in_valid=1.
REQ-025 Reset deassertion SHALL be synchronised to clk by the integrator; the module SHALL NOT contain a reset synchroniser.

Configuration
REQ-026 When macro CSWAP_SWAP_COUNT_EN is defined, the module SHALL include port swap_count.
REQ-027 With CSWAP_SWAP_COUNT_EN defined, swap_count SHALL increment by 1 on each rising edge where in_valid=1 and A=1, and saturate at 16'hFFFF.
REQ-028 When CSWAP_SWAP_COUNT_EN is undefined, the port and the counter logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-029 Truth table, WIDTH=1, in_valid=1, all 8 {A,B,C} values in sequence SHALL produce, one cycle later: 000->000, 001->001, 010->010, 011->011, 100->100, 101->110, 110->101, 111->111.
REQ-030 Wide data, WIDTH=8, inputs A=1, B=8'hA5, C=8'h3C SHALL produce B1=8'h3C and C1=8'hA5 next cycle; with A=0 the same inputs SHALL produce B1=8'hA5 and C1=8'h3C.
REQ-031 Hold: after a valid 101 input, deasserting in_valid for 3 cycles SHALL give out_valid=0 with A1B1C1 held at 110.
REQ-032 Asynchronous reset: asserting rst_n=0 between clk edges while outputs are 111 SHALL force all outputs and out_valid to 0 before the next edge.
REQ-033 Counter (macro defined): 5 valid inputs with A=1 and 3 valid inputs with A=0 SHALL give swap_count=5; a preload near 16'hFFFF followed by further valid A=1 inputs SHALL saturate at 16'hFFFF.
REQ-034 Random self-inverse check: cascading two instances with 1000 random valid inputs SHALL reproduce each input exactly 2 cycles later, with the ones-conservation check of REQ-018 passing every cycle.
